// File: rtl/fixed_pkg.sv
// Shared signed fixed-point format: B total bits, D fraction bits, two's complement.
package fixed_pkg;

    parameter int unsigned B = 20;
    parameter int unsigned D = 8;

    typedef logic [B-1:0] fixed;

    localparam fixed FIXED_1       = 20'h00100;
    localparam fixed FIXED_MAX     = 20'h7FFFF;
    // Most negative value produced on saturation; keeps the range symmetric.
    localparam fixed FIXED_MIN_SAT = 20'h80001;

endpackage

// File: rtl/fixed_div_if.sv
// Operand/result handshake bundle for fixed_div.
interface fixed_div_if;
    import fixed_pkg::*;

    logic in_valid;
    logic in_ready;
    fixed a;
    fixed b;
    logic out_valid;
    logic out_ready;
    fixed q;
    logic div_by_zero;
    logic overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, div_by_zero, overflow
    );

endinterface

// File: rtl/fixed_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module fixed_div_step
    import fixed_pkg::*;
(
    input  fixed rem_in,
    input  fixed divisor,
    input  logic next_bit,
    output fixed rem_out,
    output logic q_bit
);

    logic [B:0] trial;
    fixed       diff;

    assign trial = {rem_in, next_bit};
    // Only used when trial >= divisor, so the result fits in B bits.
    assign diff  = trial[B-1:0] - divisor;
    assign q_bit = (trial >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : trial[B-1:0];

endmodule

// File: rtl/fixed_div.sv
// Iterative signed fixed-point divider q = a / b, truncating toward zero.
// Optional macro FIXED_DIV_RADIX4_EN retires two quotient bits per RUN edge.
module fixed_div
    import fixed_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    fixed_div_if.slave bus
);

    localparam int unsigned W = B + D;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StHold} state_e;

    state_e       state;
    logic [W-1:0] dq;        // dividend bits shift out the top, quotient bits shift in the bottom
    fixed         rem;
    fixed         divisor;
    logic         sign;
    logic         a_neg;
    logic         dbz;
    logic [4:0]   cnt;
    fixed         q_r;
    logic         out_valid_r;
    logic         dbz_r;
    logic         ovf_r;

    fixed         abs_a;
    fixed         abs_b;
    fixed         rem0;
    logic         qb0;
    fixed         rem_nxt;
    logic [W-1:0] dq_nxt;
    logic         mag_big;
    logic         sat;
    fixed         res;

    assign abs_a = bus.a[B-1] ? fixed'(-bus.a) : bus.a;
    assign abs_b = bus.b[B-1] ? fixed'(-bus.b) : bus.b;

    fixed_div_step u_step0 (
        .rem_in   (rem),
        .divisor  (divisor),
        .next_bit (dq[W-1]),
        .rem_out  (rem0),
        .q_bit    (qb0)
    );

`ifdef FIXED_DIV_RADIX4_EN
    fixed rem1;
    logic qb1;

    fixed_div_step u_step1 (
        .rem_in   (rem0),
        .divisor  (divisor),
        .next_bit (dq[W-2]),
        .rem_out  (rem1),
        .q_bit    (qb1)
    );

    localparam logic [4:0] CNT_INC  = 5'd2;
    localparam logic [4:0] CNT_LAST = 5'(W - 2);
    assign rem_nxt = rem1;
    assign dq_nxt  = {dq[W-3:0], qb0, qb1};
`else
    localparam logic [4:0] CNT_INC  = 5'd1;
    localparam logic [4:0] CNT_LAST = 5'(W - 1);
    assign rem_nxt = rem0;
    assign dq_nxt  = {dq[W-2:0], qb0};
`endif

    // Anything at or above 0x80000 cannot be represented symmetrically.
    assign mag_big = |dq[W-1:B-1];
    assign sat     = mag_big | dbz;

    // Saturate, then apply sign; divide-by-zero follows the dividend's sign.
    always_comb begin
        res = '0;
        if (dbz) begin
            res = a_neg ? FIXED_MIN_SAT : FIXED_MAX;
        end else if (mag_big) begin
            res = sign ? FIXED_MIN_SAT : FIXED_MAX;
        end else begin
            res = sign ? fixed'(-dq[B-1:0]) : dq[B-1:0];
        end
    end

    // FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= StIdle;
            dq          <= '0;
            rem         <= '0;
            divisor     <= '0;
            sign        <= 1'b0;
            a_neg       <= 1'b0;
            dbz         <= 1'b0;
            cnt         <= '0;
            q_r         <= '0;
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        sign    <= bus.a[B-1] ^ bus.b[B-1];
                        a_neg   <= bus.a[B-1];
                        dq      <= {abs_a, {D{1'b0}}};
                        divisor <= abs_b;
                        dbz     <= (bus.b == '0);
                        rem     <= '0;
                        cnt     <= '0;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    rem <= rem_nxt;
                    dq  <= dq_nxt;
                    cnt <= cnt + CNT_INC;
                    if (cnt == CNT_LAST) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    q_r         <= res;
                    dbz_r       <= dbz;
                    ovf_r       <= sat & ~dbz;
                    out_valid_r <= 1'b1;
                    state       <= StHold;
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = (state == StIdle);
    assign bus.out_valid   = out_valid_r;
    assign bus.q           = q_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_fixed_div.sv
// Self-checking bench for fixed_div: vector table plus backpressure and reset sequences.
module tb_fixed_div;
    import fixed_pkg::*;

`ifdef FIXED_DIV_RADIX4_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 29;
`endif

    typedef struct {
        fixed a;
        fixed b;
        fixed q;
        logic dbz;
        logic ovf;
    } vec_t;

    typedef struct {
        fixed q;
        logic dbz;
        logic ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    vec_t vecs[12];

    fixed_div_if bus ();

    fixed_div dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, req);
        end
    endtask

    // One division; hold>0 keeps out_ready low that many cycles after out_valid rises.
    task automatic run_div(input fixed a, input fixed b, input fixed eq, input logic edbz,
                           input logic eovf, input int hold);
        int   n;
        exp_t e;
        check("in_ready_before", 32'(bus.in_ready), 32'd1);
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        e.q = eq;
        e.dbz = edbz;
        e.ovf = eovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (hold > 0 && n == 5) begin
                bus.a = 20'h12345;
                bus.b = 20'h00001;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("latency", 32'(n), 32'(LAT));
        e = sb.pop_front();
        check("q", 32'(bus.q), 32'(e.q));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        check("overflow", 32'(bus.overflow), 32'(e.ovf));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i == 3);
            bus.a = 20'h00500;
            bus.b = 20'h00100;
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_q", 32'(bus.q), 32'(e.q));
            check("hold_flags", {30'd0, bus.div_by_zero, bus.overflow}, {30'd0, e.dbz, e.ovf});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{20'h00300, 20'h00200, 20'h00180, 1'b0, 1'b0};
        vecs[1]  = '{20'hFF880, 20'h00280, 20'hFFD00, 1'b0, 1'b0};
        vecs[2]  = '{20'h00100, 20'h00300, 20'h00055, 1'b0, 1'b0};
        vecs[3]  = '{20'hFFF00, 20'h00300, 20'hFFFAB, 1'b0, 1'b0};
        vecs[4]  = '{20'h00100, 20'h00000, 20'h7FFFF, 1'b1, 1'b0};
        vecs[5]  = '{20'hFFF00, 20'h00000, 20'h80001, 1'b1, 1'b0};
        vecs[6]  = '{20'h7FFFF, 20'h00001, 20'h7FFFF, 1'b0, 1'b1};
        vecs[7]  = '{20'h80000, 20'h00100, 20'h80001, 1'b0, 1'b1};
        vecs[8]  = '{20'h00000, 20'h00300, 20'h00000, 1'b0, 1'b0};
        vecs[9]  = '{20'h00000, 20'h00000, 20'h7FFFF, 1'b1, 1'b0};
        vecs[10] = '{20'h80000, 20'h80000, 20'h00100, 1'b0, 1'b0};
        vecs[11] = '{20'h00100, 20'hFFF00, 20'hFFF00, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dbz, vecs[i].ovf, 0);
        end

        // Backpressure with stray in_valid pulses during RUN and HOLD.
        run_div(20'hFF880, 20'h00280, 20'hFFD00, 1'b0, 1'b0, 10);
        // The stray pulses must not have left a division behind.
        run_div(20'h00100, 20'h00300, 20'h00055, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of RUN.
        bus.a         = 20'h7FFFF;
        bus.b         = 20'h00003;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        run_div(20'h00300, 20'h00200, 20'h00180, 1'b0, 1'b0, 0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fixed_div.md
Name: fixed_div

Overview:
- Iterative signed fixed-point divider: q = a / b in the shared `fixed` format (B=20 total bits, D=8 fraction bits, two's complement).
- Exact counterpart to fmul: replaces the approximate reciprocal-then-multiply path wherever full precision is needed, e.g. perspective divide and normalisation.
- Consumes operands and produces the result over valid/ready handshakes, one division in flight at a time.

Parameters:
- B, 20, total fixed-point width (from the shared package; do not override locally).
- D, 8, fractional bits (from the shared package).

Ports:
- clk_in  input  1  system clock, all logic on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  divider can accept operands.
- a  input  B  dividend (fixed).
- b  input  B  divisor (fixed).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- q  output  B  quotient (fixed).
- div_by_zero  output  1  b was 0 for this result; qualified by out_valid.
- overflow  output  1  quotient was saturated, b nonzero; qualified by out_valid.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE.
  - in_ready=1 is combinational from IDLE.
  - out_valid=0, q=0, div_by_zero=0, overflow=0.
  - Any in-flight division is discarded.
- States:
  - IDLE: in_ready=1. A transfer is in_valid&in_ready at an edge. On a transfer, register:
    - sign = a[B-1]^b[B-1];
    - |a| zero-extended to B+D bits and shifted left by D;
    - |b| as B unsigned bits (|0x80000| = 0x80000);
    - dbz = (b==0);
    - step counter = 0.
    Then go to RUN.
  - RUN: one restoring-division step per edge, MSB first:
    - rem = {rem, next dividend bit};
    - if rem >= |b|, subtract and shift in a quotient bit of 1, else shift in 0.
    - Runs B+D = 28 steps (counter 0..27). After the step with counter 27, go to FIX.
  - FIX (one edge):
    - Saturation: magnitude > 0x7FFFF, or dbz, clamps to 0x7FFFF.
    - Sign is then applied (negate if sign=1).
    - dbz: the result is +0x7FFFF if a>=0, else -0x7FFFF (0x80001).
    - Register q, div_by_zero, overflow (overflow=1 only when saturated and !dbz).
    - out_valid<=1; go to HOLD.
  - HOLD: q and the flags are stable while out_valid=1. When out_valid&out_ready at an edge: out_valid<=0, go to IDLE.
- Latency:
  - The accepting edge is edge k. out_valid rises after edge k+29.
  - Latency is constant, including divide-by-zero.
  - in_ready returns the cycle after the output handshake, so throughput is one division per 30 cycles minimum.
- Arithmetic:
  - Truncation toward zero; the remainder is discarded.
  - Result range is symmetric ±0x7FFFF; 0x80000 is never produced.
  - a=0 with b≠0 gives q=0, no flags.
- in_valid while not in IDLE: ignored, not captured.
- out_ready asserted with out_valid=0: no effect.
- in_valid must hold a and b stable until the transfer. The divider captures them on the transfer edge only.

Optional Feature:
- Macro FIXED_DIV_RADIX4_EN.
- Defined: RUN retires 2 quotient bits per edge using two cascaded step instances. This gives 14 RUN edges, and out_valid rises after edge k+15. Results and flags are bit-identical to the radix-2 build.
- Undefined: the radix-2 behaviour above, with 29-cycle latency.

Decomposition:
- fixed_pkg holds:
  - parameters B and D;
  - typedef fixed;
  - constants FIXED_1 (0x00100) and FIXED_MAX (0x7FFFF);
  - a shared FIXED_MIN_SAT (0x80001) constant.
- Sub-module fixed_div_step: purely combinational, one restoring step. Its interface is rem_in, divisor, next_bit → rem_out, q_bit. It is instantiated once, or twice under FIXED_DIV_RADIX4_EN.
- The FSM, counter, sign/saturation and handshake logic live in fixed_div.

Test Plan:
- a=0x00300 (3.0), b=0x00200 (2.0), out_ready=1 → q=0x00180 (1.5), flags 0; out_valid exactly 29 edges after accept (15 with FIXED_DIV_RADIX4_EN).
- a=0xFF880 (-7.5), b=0x00280 (2.5) → q=0xFFD00 (-3.0). Then a=0x00100, b=0x00300 → q=0x00055. Then a=0xFFF00, b=0x00300 → q=0xFFFAB (truncation toward zero).
- a=0x00100, b=0 → q=0x7FFFF, div_by_zero=1, overflow=0. Then a=0xFFF00, b=0 → q=0x80001, div_by_zero=1.
- a=0x7FFFF, b=0x00001 → q=0x7FFFF, overflow=1. Then a=0x80000, b=0x00100 → q=0x80001, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises → q and flags stable, in_ready=0, an in_valid pulse during RUN/HOLD is ignored. After the handshake, in_ready=1 on the next cycle.
- Assert rst_in asynchronously mid-RUN (step 10) → out_valid=0 and in_ready=1 immediately. The next division 0x00300/0x00200 completes correctly with q=0x00180.
